// File: rtl/mac_acc.sv
// mac_acc: binary-activation multiply-accumulate stage.
// Accumulates n_terms (activation bit, signed weight) beats onto a signed
// bias with per-step saturation, then publishes the sum on agg_data.
//
// Handshake: a beat transfers on a rising edge where in_valid and in_ready
// are both high. in_ready depends only on the FSM state, never on in_valid.
// out_valid is a one-cycle pulse that coincides with each agg_data update.
module mac_acc #(
  parameter int agg_width = 12,
  parameter int wt_width  = 4,
  parameter int n_terms   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [agg_width-1:0] bias_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 act_in,
  input  logic [wt_width-1:0]  wt_in,
  output logic [agg_width-1:0] agg_data,
  output logic                 out_valid,
  output logic                 sat_flag,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int cnt_w = $clog2(n_terms);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(n_terms - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [agg_width-1:0] acc;
  logic [cnt_w-1:0]     cnt;
  logic                 beat_ok;

  // Saturating add, computed one bit wider than the accumulator.
  logic [agg_width:0]   addend;
  logic [agg_width:0]   sum_ext;
  logic                 ovf;
  logic [agg_width-1:0] acc_nxt;

  assign beat_ok   = in_valid & in_ready;
  assign dbg_state = state;

  // Sign-extend the gated weight, add, and clamp on overflow.
  always_comb begin
    addend  = '0;
    sum_ext = '0;
    ovf     = 1'b0;
    acc_nxt = acc;
    if (act_in) begin
      addend = {{(agg_width + 1 - wt_width){wt_in[wt_width-1]}}, wt_in};
    end
    sum_ext = {acc[agg_width-1], acc} + addend;
    ovf     = sum_ext[agg_width] ^ sum_ext[agg_width-1];
    if (ovf) begin
      // Top bit of the wide sum is the true sign: negative clamps to min.
      acc_nxt = sum_ext[agg_width] ? {1'b1, {(agg_width-1){1'b0}}}
                                   : {1'b0, {(agg_width-1){1'b1}}};
    end else begin
      acc_nxt = sum_ext[agg_width-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (beat_ok && (cnt == last_cnt)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: accumulator, beat counter, sticky saturation, result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      agg_data  <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= bias_in;
            cnt      <= '0;
            sat_flag <= 1'b0;
          end
        end
        ACCUM: begin
          if (beat_ok) begin
            acc <= acc_nxt;
            cnt <= cnt + cnt_w'(1);
            if (ovf) sat_flag <= 1'b1;
          end
        end
        DONE: begin
          agg_data  <= acc;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_acc.sv
// tb_mac_acc: randomized stimulus against a plain-arithmetic reference model.
module tb_mac_acc;

  localparam int AW = 12;
  localparam int WW = 4;
  localparam int NT = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] bias_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          act_in = 1'b0;
  logic [WW-1:0] wt_in = '0;
  logic [AW-1:0] agg_data;
  logic          out_valid;
  logic          sat_flag;
  logic          busy;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  mac_acc #(.agg_width(AW), .wt_width(WW), .n_terms(NT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bias_in   (bias_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act_in    (act_in),
    .wt_in     (wt_in),
    .agg_data  (agg_data),
    .out_valid (out_valid),
    .sat_flag  (sat_flag),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // Expected entries: {sat_flag, agg_data}.
  logic [AW:0] exp_q[$];

  bit act_a[NT];
  int wt_a[NT];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Running integer sum, clamped to the signed range after every add.
  function automatic logic [AW:0] model(input int bias);
    int lo;
    int hi;
    int s;
    bit sat;
    lo  = -(1 << (AW - 1));
    hi  = (1 << (AW - 1)) - 1;
    s   = bias;
    sat = 1'b0;
    for (int i = 0; i < NT; i++) begin
      if (act_a[i]) s = s + wt_a[i];
      if (s > hi) begin s = hi; sat = 1'b1; end
      if (s < lo) begin s = lo; sat = 1'b1; end
    end
    return {sat, AW'(s)};
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [AW:0] e;
    forever begin
      @(negedge clk);
      if (rst && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid: got agg_data=%0h with no pending result", agg_data);
        end else begin
          e = exp_q.pop_front();
          check("agg_data", int'(agg_data), int'(e[AW-1:0]));
          check("sat_flag", int'(sat_flag), int'(e[AW]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int bias);
    start   = 1'b1;
    bias_in = AW'(bias);
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  // One beat; optional idle gaps (with junk data and stray start pulses).
  task automatic send_beat(input bit act, input int wt, input bit gaps, input bit noise);
    int n;
    int guard;
    if (gaps) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        in_valid = 1'b0;
        act_in   = 1'($urandom_range(0, 1));
        wt_in    = WW'($urandom);
        start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bias_in  = AW'($urandom);
        @(posedge clk); #1;
      end
    end
    start    = 1'b0;
    in_valid = 1'b1;
    act_in   = act;
    wt_in    = WW'(wt);
    guard    = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: in_ready=%0d required 1", in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Full neuron from act_a/wt_a; ends in IDLE one edge after the result.
  task automatic run_neuron(input int bias, input bit gaps, input bit noise);
    exp_q.push_back(model(bias));
    pulse_start(bias);
    for (int i = 0; i < NT; i++) send_beat(act_a[i], wt_a[i], gaps, noise);
    // Last beat accepted on the previous edge: FSM is in DONE now.
    check("done_no_valid_yet", int'(out_valid), 0);
    start   = noise;
    bias_in = AW'($urandom);
    @(posedge clk); #1;
    start   = 1'b0;
    check("latency_out_valid", int'(out_valid), 1);
    check("idle_after_done", int'(busy), 0);
  endtask

  task automatic fill(input bit act, input int wt);
    for (int i = 0; i < NT; i++) begin
      act_a[i] = act;
      wt_a[i]  = wt;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ov_cnt;
    int b;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_agg_data", int'(agg_data), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;

    // No output without start.
    ov_cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) ov_cnt++;
    end
    check("idle_no_out_valid", ov_cnt, 0);

    // Basic: 5 + 16 = 21.
    fill(1'b1, 1);
    run_neuron(5, 1'b0, 1'b0);
    check("basic_agg_data", int'(agg_data), 21);

    // Masking: all activations off.
    fill(1'b0, 7);
    run_neuron(-3, 1'b0, 1'b0);
    check("mask_agg_data", int'(agg_data), 'hFFD);

    // Mixed: four active beats of -2.
    for (int i = 0; i < NT; i++) begin
      act_a[i] = (i % 4 == 1);
      wt_a[i]  = (i % 4 == 1) ? -2 : int'($urandom_range(0, 15)) - 8;
    end
    run_neuron(100, 1'b0, 1'b0);
    check("mixed_agg_data", int'(agg_data), 92);

    // Saturation, both rails.
    fill(1'b1, 7);
    run_neuron(2000, 1'b0, 1'b0);
    check("sat_hi_data", int'(agg_data), 'h7FF);
    check("sat_hi_flag", int'(sat_flag), 1);
    fill(1'b1, -8);
    run_neuron(-2000, 1'b0, 1'b0);
    check("sat_lo_data", int'(agg_data), 'h800);
    check("sat_lo_flag", int'(sat_flag), 1);

    // Flow control with gaps and stray start pulses.
    fill(1'b1, 1);
    run_neuron(0, 1'b1, 1'b1);
    check("flow_agg_data", int'(agg_data), 16);

    // Reset mid-ACCUM after 8 beats: partial sum discarded.
    fill(1'b1, 3);
    pulse_start(50);
    for (int i = 0; i < 8; i++) send_beat(1'b1, 3, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_agg_data", int'(agg_data), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_sat_flag", int'(sat_flag), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    ov_cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) ov_cnt++;
    end
    check("midrst_no_out_valid", ov_cnt, 0);
    run_neuron(50, 1'b0, 1'b0);
    check("after_rst_agg_data", int'(agg_data), 98);

    // Randomized neurons, biases spread over the range and near the rails.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NT; i++) begin
        act_a[i] = 1'($urandom_range(0, 1));
        wt_a[i]  = int'($urandom_range(0, 15)) - 8;
      end
      case (n % 3)
        0:       b = int'($urandom_range(0, 4095)) - 2048;
        1:       b = int'($urandom_range(1980, 2047));
        default: b = -int'($urandom_range(1980, 2048));
      endcase
      run_neuron(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Drain the scoreboard.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
